// File: rtl/sreg_shift_ctrl.sv
// Frame controller: accepts a parallel word over valid/ready, serialises it on sout, then idles GAP_CYC cycles.
// Optional even-parity bit appended after the data when SREG_PARITY_EN is defined.
module sreg_shift_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_en,
  output logic              done,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SREG_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif
  localparam logic [1:0] ST_GAP   = 2'd3;

  // After the last frame bit the controller either rests in GAP or returns straight to IDLE
  localparam logic [1:0] ST_POST = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

  if (DATA_W < 2) begin : g_bad_data_w
    $error("sreg_shift_ctrl: DATA_W must be >= 2");
  end
  if (GAP_CYC > 15) begin : g_bad_gap_cyc
    $error("sreg_shift_ctrl: GAP_CYC must be 0..15");
  end

  logic [1:0]        state_q,   state_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              sout_q,    sout_d;
  logic              sout_en_q, sout_en_d;
  logic              done_q,    done_d;
`ifdef SREG_PARITY_EN
  logic              par_q,     par_d;
`endif
  logic              accept;

  assign din_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = din_valid && din_ready;

  assign sout    = sout_q;
  assign sout_en = sout_en_q;
  assign done    = done_q;

  // Next-state and registered-output decode; shreg always holds the next bit at its head
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sout_d    = 1'b0;
    sout_en_d = 1'b0;
    done_d    = 1'b0;
`ifdef SREG_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          sout_d    = MSB_FIRST ? din[DATA_W-1] : din[0];
          shreg_d   = MSB_FIRST ? {din[DATA_W-2:0], 1'b0} : {1'b0, din[DATA_W-1:1]};
          sout_en_d = 1'b1;
          bit_cnt_d = '0;
`ifdef SREG_PARITY_EN
          par_d     = ^din;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SREG_PARITY_EN
          state_d   = ST_PAR;
          sout_d    = par_q;
          sout_en_d = 1'b1;
`else
          state_d   = ST_POST;
          done_d    = 1'b1;
          gap_cnt_d = '0;
`endif
        end else begin
          sout_d    = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
          shreg_d   = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
          sout_en_d = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef SREG_PARITY_EN
      ST_PAR: begin
        state_d   = ST_POST;
        done_d    = 1'b1;
        gap_cnt_d = '0;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sout_q    <= 1'b0;
      sout_en_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SREG_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sout_q    <= sout_d;
      sout_en_q <= sout_en_d;
      done_q    <= done_d;
`ifdef SREG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
